bcd_sevenseg_scan: RTL and testbench

- Downstream display stage for the adder/BCD-converter datapath on the Basys3 board.
- Captures the 4-digit packed BCD word on each new conversion-ready event and holds it.
- Time-multiplexes the held word onto the 4-digit common-anode seven-segment display, with optional leading-zero blanking.
- Sole consumer of the converter's bcd_d_out/rdy pair.

---
 rtl/bcd_sevenseg_scan_if.sv | 20 ++
 rtl/bcd_sevenseg_scan.sv | 114 +++++++++++
 tb/tb_bcd_sevenseg_scan.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_sevenseg_scan_if.sv
// Converter-to-display bundle: packed BCD with ready strobe in,
// multiplexed common-anode seven-segment drive out.
interface bcd_sevenseg_scan_if;
    logic [15:0] bcd_d_in;
    logic        rdy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        disp_valid;

    modport master (
        output bcd_d_in, rdy,
        input  an, seg, dp, disp_valid
    );

    modport slave (
        input  bcd_d_in, rdy,
        output an, seg, dp, disp_valid
    );
endinterface

// File: rtl/bcd_sevenseg_scan.sv
// Captures a 4-digit BCD word on each rdy rising edge and scans it
// onto a common-anode display with optional leading-zero blanking.
module bcd_sevenseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    bcd_sevenseg_scan_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic          rdy_q;
    logic [15:0]   disp_q;
    logic          valid_q;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic [3:0]    nib;
    logic          lz;
    logic          blank;
    logic [6:0]    seg_d;

    // lz: this digit and every more significant digit are zero
    always_comb begin
        nib = disp_q[3:0];
        lz  = 1'b0;
        unique case (idx)
            2'd0: begin
                nib = disp_q[3:0];
                lz  = 1'b0;
            end
            2'd1: begin
                nib = disp_q[7:4];
                lz  = (disp_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib = disp_q[11:8];
                lz  = (disp_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib = disp_q[15:12];
                lz  = (disp_q[15:12] == 4'h0);
            end
        endcase
        blank = !valid_q || (BLANK_LZ && lz);
    end

    always_comb begin
        seg_d = 7'b0111111;
        case (nib)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b0111111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            disp_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            rdy_q <= bus.rdy;
            if (bus.rdy && !rdy_q) begin
                disp_q  <= bus.bcd_d_in;
                valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else if (blank) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= seg_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.disp_valid = valid_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed bench for bcd_sevenseg_scan: three parameterisations share
// stimulus, a digit-position model checks every cycle.
module tb_bcd_sevenseg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic        rdy;
    bit          chk;

    int checks = 0;
    int errors = 0;

    localparam int DIV [3] = '{4, 4, 1};
    localparam bit BLZ [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    bcd_sevenseg_scan_if bif0 ();
    bcd_sevenseg_scan_if bif1 ();
    bcd_sevenseg_scan_if bif2 ();

    assign bif0.bcd_d_in = bcd;
    assign bif1.bcd_d_in = bcd;
    assign bif2.bcd_d_in = bcd;
    assign bif0.rdy = rdy;
    assign bif1.rdy = rdy;
    assign bif2.rdy = rdy;

    bcd_sevenseg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bif0)
    );
    bcd_sevenseg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bif1)
    );
    bcd_sevenseg_scan #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bif2)
    );

    logic [3:0] o_an  [3];
    logic [6:0] o_seg [3];
    logic       o_dp  [3];
    logic       o_val [3];

    assign o_an[0] = bif0.an;
    assign o_an[1] = bif1.an;
    assign o_an[2] = bif2.an;
    assign o_seg[0] = bif0.seg;
    assign o_seg[1] = bif1.seg;
    assign o_seg[2] = bif2.seg;
    assign o_dp[0] = bif0.dp;
    assign o_dp[1] = bif1.dp;
    assign o_dp[2] = bif2.dp;
    assign o_val[0] = bif0.disp_valid;
    assign o_val[1] = bif1.disp_valid;
    assign o_val[2] = bif2.disp_valid;

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic bit is_lit(input int v, input bit valid,
                                  input int i, input bit blz);
        if (!valid) return 1'b0;
        if (blz && i != 0 && (v >> (4 * i)) == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Model: slot index is elapsed edges since reset divided by the slot
    // length; outputs show the state seen just before each edge.
    int         edges;
    int         m_val;
    bit         m_valid;
    bit         m_rdy_q;
    logic [3:0] e_an  [3];
    logic [6:0] e_seg [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges   <= 0;
            m_val   <= 0;
            m_valid <= 1'b0;
            m_rdy_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                e_an[k]  <= 4'b1111;
                e_seg[k] <= 7'b1111111;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (edges / DIV[k]) % 4;
                if (is_lit(m_val, m_valid, i, BLZ[k])) begin
                    e_an[k]  <= 4'(~(1 << i));
                    e_seg[k] <= glyph((m_val >> (4 * i)) & 15);
                end else begin
                    e_an[k]  <= 4'b1111;
                    e_seg[k] <= 7'b1111111;
                end
            end
            edges <= edges + 1;
            m_rdy_q <= rdy;
            if (rdy && !m_rdy_q) begin
                m_val   <= int'(bcd);
                m_valid <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("an%0d", k), int'(o_an[k]), int'(e_an[k]));
                check($sformatf("seg%0d", k), int'(o_seg[k]), int'(e_seg[k]));
                check($sformatf("dp%0d", k), int'(o_dp[k]), 1);
                check($sformatf("valid%0d", k), int'(o_val[k]), int'(m_valid));
            end
        end
    endtask

    int sc_cnt [6];
    int sc_seg [4];

    task automatic scan(input int k);
        int d;
        for (int j = 0; j < 6; j++) sc_cnt[j] = 0;
        for (int j = 0; j < 4; j++) sc_seg[j] = -1;
        repeat (16) begin
            cycle();
            case (o_an[k])
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                4'b1111: d = 4;
                default: d = 5;
            endcase
            sc_cnt[d]++;
            if (d < 4) sc_seg[d] = int'(o_seg[k]);
        end
    endtask

    task automatic digit(input string tag, input int d, input int seg);
        check({tag, "_len"}, sc_cnt[d], 4);
        check({tag, "_seg"}, sc_seg[d], seg);
    endtask

    task automatic pulse(input logic [15:0] v);
        bcd = v;
        rdy = 1'b1;
        cycle();
        rdy = 1'b0;
        repeat (3) cycle();
    endtask

    int  a_hist [25];
    int  first;
    bit  found;

    initial begin
        chk   = 1'b0;
        bcd   = 16'h0000;
        rdy   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        chk   = 1'b1;

        repeat (40) cycle();
        check("rst_an", int'(o_an[0]), 4'hF);
        check("rst_seg", int'(o_seg[0]), 7'h7F);
        check("rst_dp", int'(o_dp[0]), 1);
        check("rst_valid", int'(o_val[0]), 0);

        bcd = 16'h0015;
        rdy = 1'b1;
        cycle();
        rdy = 1'b0;
        check("valid_next", int'(o_val[0]), 1);
        repeat (3) cycle();
        scan(0);
        digit("v15_d0", 0, 7'b0010010);
        digit("v15_d1", 1, 7'b1111001);
        check("v15_blank", sc_cnt[4], 8);

        pulse(16'h0000);
        scan(0);
        digit("z_blz_d0", 0, 7'b1000000);
        check("z_blz_blank", sc_cnt[4], 12);
        scan(1);
        for (int d = 0; d < 4; d++)
            digit($sformatf("z_all_d%0d", d), d, 7'b1000000);

        bcd = 16'h0012;
        rdy = 1'b1;
        repeat (3) cycle();
        bcd = 16'h0030;
        repeat (3) cycle();
        scan(0);
        digit("held_d0", 0, 7'b0100100);
        digit("held_d1", 1, 7'b1111001);
        rdy = 1'b0;
        cycle();
        rdy = 1'b1;
        repeat (3) cycle();
        scan(0);
        digit("re_d0", 0, 7'b1000000);
        digit("re_d1", 1, 7'b0110000);
        rdy = 1'b0;
        cycle();

        pulse(16'h90A7);
        scan(0);
        digit("bad_d0", 0, 7'b1111000);
        digit("bad_d1", 1, 7'b0111111);
        digit("bad_d2", 2, 7'b1000000);
        digit("bad_d3", 3, 7'b0010000);

        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cycle();
            if (o_an[0] == 4'b1011) found = 1'b1;
        end
        check("reach_slot2", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", int'(o_an[0]), 4'hF);
        check("async_valid", int'(o_val[0]), 0);
        repeat (3) cycle();
        bcd = 16'h0015;
        rst_n = 1'b1;

        for (int k = 1; k <= 24; k++) begin
            rdy = (k == 10);
            cycle();
            a_hist[k] = int'(o_an[0]);
        end
        rdy = 1'b0;
        first = 0;
        for (int k = 24; k >= 1; k--)
            if (a_hist[k] != 4'hF) first = k;
        check("restart_first", first, 17);
        for (int k = 17; k <= 20; k++)
            check($sformatf("restart_d0_%0d", k), a_hist[k], 4'b1110);
        check("restart_d1", a_hist[21], 4'b1101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
